// File: rtl/fulladder_bist_pkg.sv
// Shared types, constants and golden model for the full-adder built-in self test.
package fulladder_bist_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Returns {cout, sum} for a vector ordered {a, b, cin}.
  function automatic logic [1:0] golden(input logic [VEC_W-1:0] v);
    logic s;
    logic c;
    s = ^v;
    c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return {c, s};
  endfunction

endpackage

// File: rtl/fulladder_golden.sv
// Combinational expected sum/carry for one {a, b, cin} vector.
module fulladder_golden
  import fulladder_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp_sum,
  output logic             exp_cout
);

  assign {exp_cout, exp_sum} = golden(vec);

endmodule

// File: rtl/fulladder_bist.sv
// BIST controller: walks a full adder through all 8 input vectors and checks each result.
// Optional per-vector fail_mask output enabled by defining FULLADDER_BIST_FAIL_MASK_EN.
module fulladder_bist
  import fulladder_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec
`ifdef FULLADDER_BIST_FAIL_MASK_EN
  ,
  output logic [NUM_VECTORS-1:0] fail_mask
`endif
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [VEC_W-1:0] vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_fail_q;
  logic             exp_sum;
  logic             exp_cout;
  logic             mismatch;
  logic             settled;
  logic             last_vec;
  logic             launch;
  logic [ERR_W-1:0] err_next;

  fulladder_golden u_golden (
    .vec      (vec_q),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  // Stimulus comes straight from the vector register, so it is registered by construction.
  assign a   = vec_q[2];
  assign b   = vec_q[1];
  assign cin = vec_q[0];

  assign mismatch = (sum != exp_sum) || (cout != exp_cout);
  assign settled  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign last_vec = (vec_q == VEC_W'(NUM_VECTORS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (settled) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : DRIVE;
      DONE:    if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch   = start && ((state_q == IDLE) || (state_q == DONE));
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q          <= '0;
      cnt_q          <= '0;
      seen_fail_q    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
`ifdef FULLADDER_BIST_FAIL_MASK_EN
      fail_mask      <= '0;
`endif
    end else if (launch) begin
      vec_q          <= '0;
      cnt_q          <= '0;
      seen_fail_q    <= 1'b0;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
`ifdef FULLADDER_BIST_FAIL_MASK_EN
      fail_mask      <= '0;
`endif
    end else if (state_q == DRIVE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (state_q == SAMPLE) begin
      err_count <= err_next;
      if (mismatch) begin
        seen_fail_q <= 1'b1;
        if (!seen_fail_q) first_fail_vec <= vec_q;
`ifdef FULLADDER_BIST_FAIL_MASK_EN
        fail_mask[vec_q] <= 1'b1;
`endif
      end
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == '0);
      end else begin
        vec_q <= vec_q + VEC_W'(1);
        cnt_q <= '0;
      end
    end
  end

endmodule
